// File: rtl/sakura_g_ring_osc_uart_top.sv
// SAKURA-G ring-oscillator load bank controlled by a 16-bit enable word.
// The word arrives as two UART bytes; every valid byte is echoed back.
module sakura_g_ring_osc_uart_top #(
  parameter int CLK_FREQ  = 48000000,
  parameter int BAUD      = 57600,
  parameter int N_RO      = 16,
  parameter int RO_STAGES = 5,
  parameter bit SIM_MODEL = 1'b0
) (
  input  logic M_CLK_OSC,
  input  logic M_RESET_B,
  input  logic FTDI_BDBUS_0,
  output logic FTDI_BDBUS_1,
  output logic M_HEADER,
  output logic M_LED_0,
  output logic M_LED_1
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } st_t;

  logic clk;
  logic rst;
  assign clk = M_CLK_OSC;
  assign rst = M_RESET_B;

  logic rx_s1_q, rx_s2_q, rx_s3_q;
  st_t rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic rx_stb_q, rx_stb_d;
  logic ferr_q, ferr_d;

  logic pair_q, pair_d;
  logic [7:0] hi_q, hi_d;
  logic [15:0] en_q, en_d;
  logic hdr_q, hdr_d;
  logic led0_q, led0_d;

  logic [7:0] f0_q, f0_d, f1_q, f1_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic pop, push;

  st_t tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic tx_q, tx_d;

  // Start is a falling edge so a line held low after a bad stop bit
  // cannot retrigger the receiver.
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_stb_d = 1'b0;
    ferr_d   = ferr_q;
    unique case (rx_st_q)
      S_IDLE: begin
        if (!rx_s2_q && rx_s3_q) begin
          rx_st_d  = S_START;
          rx_cnt_d = '0;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_st_d = S_IDLE;
          if (rx_s2_q) rx_stb_d = 1'b1;
          else ferr_d = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_comb begin
    pair_d = pair_q;
    hi_d   = hi_q;
    en_d   = en_q;
    if (rx_stb_q) begin
      if (!pair_q) begin
        hi_d   = rx_sh_q;
        pair_d = 1'b1;
      end else begin
        en_d   = {hi_q, rx_sh_q};
        pair_d = 1'b0;
      end
    end
    hdr_d  = |en_d[N_RO-1:0];
    led0_d = |en_d[N_RO-1:0];
  end

  // Pop and push may coincide; the pop frees the slot first.
  always_comb begin
    pop    = (tx_st_q == S_IDLE) && (fcnt_q != 2'd0);
    push   = rx_stb_q && ((fcnt_q != 2'd2) || pop);
    f0_d   = f0_q;
    f1_d   = f1_q;
    fcnt_d = fcnt_q;
    if (pop) begin
      f0_d   = f1_q;
      fcnt_d = fcnt_q - 2'd1;
    end
    if (push) begin
      if (fcnt_d == 2'd0) f0_d = rx_sh_q;
      else f1_d = rx_sh_q;
      fcnt_d = fcnt_d + 2'd1;
    end
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    unique case (tx_st_q)
      S_IDLE: begin
        if (pop) begin
          tx_sh_d  = f0_q;
          tx_cnt_d = '0;
          tx_st_d  = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          tx_bit_d = '0;
          tx_st_d  = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          if (tx_bit_q == 3'd7) tx_st_d = S_STOP;
          else tx_bit_d = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_END) tx_st_d = S_IDLE;
        else tx_cnt_d = tx_cnt_q + CW'(1);
      end
      default: tx_st_d = S_IDLE;
    endcase
    tx_d = (tx_st_d == S_START) ? 1'b0 :
           (tx_st_d == S_DATA)  ? tx_sh_d[0] : 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      rx_s3_q  <= 1'b1;
      rx_st_q  <= S_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
      rx_stb_q <= 1'b0;
      ferr_q   <= 1'b0;
      pair_q   <= 1'b0;
      hi_q     <= '0;
      en_q     <= '0;
      hdr_q    <= 1'b0;
      led0_q   <= 1'b0;
      f0_q     <= '0;
      f1_q     <= '0;
      fcnt_q   <= '0;
      tx_st_q  <= S_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      rx_s1_q  <= FTDI_BDBUS_0;
      rx_s2_q  <= rx_s1_q;
      rx_s3_q  <= rx_s2_q;
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
      rx_stb_q <= rx_stb_d;
      ferr_q   <= ferr_d;
      pair_q   <= pair_d;
      hi_q     <= hi_d;
      en_q     <= en_d;
      hdr_q    <= hdr_d;
      led0_q   <= led0_d;
      f0_q     <= f0_d;
      f1_q     <= f1_d;
      fcnt_q   <= fcnt_d;
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      tx_q     <= tx_d;
    end
  end

  assign FTDI_BDBUS_1 = tx_q;
  assign M_HEADER     = hdr_q;
  assign M_LED_0      = led0_q;
  assign M_LED_1      = ferr_q;

  logic [N_RO-1:0] ro_out;

  if (SIM_MODEL) begin : g_sim
    logic [N_RO-1:0] ro_q, ro_d;
    assign ro_d = ~ro_q | ~en_q[N_RO-1:0];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) ro_q <= '1;
      else ro_q <= ro_d;
    end
    assign ro_out = ro_q;
  end else begin : g_hw
    for (genvar i = 0; i < N_RO; i++) begin : g_ring
      (* keep = "true", dont_touch = "true" *)
      logic [RO_STAGES-1:0] n;
      assign n[0] = ~(en_q[i] & n[RO_STAGES-1]);
      for (genvar j = 1; j < RO_STAGES; j++) begin : g_inv
        assign n[j] = ~n[j-1];
      end
      assign ro_out[i] = n[RO_STAGES-1];
    end
  end

  // Sink for the ring outputs; it only exists to keep the rings alive.
  (* keep = "true", dont_touch = "true" *)
  logic ro_mix_unused_q;
  logic ro_mix_d;
  assign ro_mix_d = ^ro_out;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ro_mix_unused_q <= 1'b0;
    else ro_mix_unused_q <= ro_mix_d;
  end

endmodule

// File: tb/tb_sakura_g_ring_osc_uart_top.sv
// Directed + randomized bench for the ring-oscillator UART top.
// A byte/word model predicts the enable word, status and echo stream.
module tb_sakura_g_ring_osc_uart_top;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx, hdr, led0, led1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] m_word = '0;
  logic [7:0]  m_hi   = '0;
  logic        m_half = 1'b0;
  logic        m_ferr = 1'b0;

  logic [7:0] exp_q[$];
  int         exp_t[$];
  logic [7:0] got_q[$];
  int         got_t[$];
  logic       got_sb[$];

  sakura_g_ring_osc_uart_top #(
    .CLK_FREQ (1600000),
    .BAUD     (100000),
    .N_RO     (16),
    .RO_STAGES(5),
    .SIM_MODEL(1'b1)
  ) dut (
    .M_CLK_OSC   (clk),
    .M_RESET_B   (rst),
    .FTDI_BDBUS_0(rx),
    .FTDI_BDBUS_1(tx),
    .M_HEADER    (hdr),
    .M_LED_0     (led0),
    .M_LED_1     (led1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sb);
    logic [9:0] fr;
    int st;
    fr = {sb, b, 1'b0};
    st = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) st = cyc;
      rx = fr[i];
      idle(CPB);
    end
    rx = 1'b1;
    if (sb) begin
      exp_q.push_back(b);
      exp_t.push_back(st);
      if (!m_half) begin
        m_hi   = b;
        m_half = 1'b1;
      end else begin
        m_word = {m_hi, b};
        m_half = 1'b0;
      end
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_word"}, dut.en_q, m_word);
    check({tag, "_hdr"}, hdr, m_word != 16'h0);
    check({tag, "_led0"}, led0, m_word != 16'h0);
    check({tag, "_led1"}, led1, m_ferr);
  endtask

  task automatic check_rings(input string tag);
    logic [15:0] r0, r1;
    r0 = dut.ro_out;
    @(negedge clk);
    r1 = dut.ro_out;
    check({tag, "_toggle"}, r0 ^ r1, m_word);
    check({tag, "_high"}, r0 | m_word, 16'hFFFF);
  endtask

  task automatic check_echo(input string tag);
    int lat;
    for (int k = 0; k < 40 * CPB && got_q.size() < exp_q.size(); k++)
      @(negedge clk);
    idle(2 * CPB);
    check({tag, "_echo_n"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      lat = got_t.pop_front() - exp_t.pop_front();
      check({tag, "_echo_b"}, got_q.pop_front(), exp_q.pop_front());
      check({tag, "_echo_sb"}, got_sb.pop_front(), 1'b1);
      check({tag, "_echo_lat"}, (lat > 0) && (lat <= 2 * CPB), 1'b1);
    end
    exp_q.delete();
    exp_t.delete();
    got_q.delete();
    got_t.delete();
    got_sb.delete();
  endtask

  // Host-side UART receiver for the echo stream.
  initial begin : mon
    logic [7:0] b;
    int t0;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && rst === 1'b0) begin
        t0 = cyc;
        idle(CPB / 2);
        for (int i = 0; i < 8; i++) begin
          idle(CPB);
          b[i] = tx;
        end
        idle(CPB);
        got_q.push_back(b);
        got_t.push_back(t0);
        got_sb.push_back(tx);
      end
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] a, b;
    rst = 1'b1;
    rx  = 1'b1;
    idle(4);
    rst = 1'b0;
    idle(2);
    check("rst_tx", tx, 1'b1);
    check_status("rst");
    check("rst_rings", dut.ro_out, 16'hFFFF);

    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(2);
    check_status("zero");
    check_echo("zero");

    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(2);
    check_status("ones");
    check_rings("ones");
    check_echo("ones");

    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(2);
    check_status("off");
    check_rings("off");
    check_echo("off");

    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(3 * CPB);
    check_status("glitch");
    check("glitch_echo_n", got_q.size(), 0);

    send_byte(8'h12, 1'b0);
    idle(CPB);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    idle(2);
    check_status("ferr");
    check_rings("ferr");
    check_echo("ferr");

    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      idle(CPB);
    end
    rst = 1'b1;
    rx  = 1'b1;
    m_word = '0;
    m_half = 1'b0;
    m_ferr = 1'b0;
    idle(4);
    rst = 1'b0;
    idle(2);
    check_status("midrst");
    check("midrst_tx", tx, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    idle(2);
    check_status("after_rst");
    check_echo("after_rst");

    for (int n = 0; n < 5; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        send_byte(8'($urandom), 1'b0);
        idle(CPB);
      end
      send_byte(a, 1'b1);
      idle($urandom_range(0, 2 * CPB));
      send_byte(b, 1'b1);
      idle(2);
      check_status("rand");
      check_rings("rand");
      check_echo("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
